// File: rtl/custom_busmatrix_input_stage_if.sv
// AHB slave-port bus and decoder-side signals around one bus-matrix input stage.
// The slave modport is the input stage's view; master is the upstream/decoder side.
interface custom_busmatrix_input_stage_if;
  // master side of the AHB slave port
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic [1:0]  HRESPS;
  // decoder / output-stage side
  logic        sel_in;
  logic [31:0] addr_in;
  logic [1:0]  trans_in;
  logic        write_in;
  logic [2:0]  size_in;
  logic [2:0]  burst_in;
  logic [3:0]  prot_in;
  logic        held_tran_in;
  logic        active_in;
  logic        readyout_in;
  logic [1:0]  resp_in;

  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HREADYS,
    input  active_in, readyout_in, resp_in,
    output HREADYOUTS, HRESPS,
    output sel_in, addr_in, trans_in, write_in, size_in, burst_in, prot_in, held_tran_in
  );

  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HREADYS,
    output active_in, readyout_in, resp_in,
    input  HREADYOUTS, HRESPS,
    input  sel_in, addr_in, trans_in, write_in, size_in, burst_in, prot_in, held_tran_in
  );
endinterface

// File: rtl/custom_busmatrix_input_stage.sv
// Bus-matrix input stage: passes the master's address phase straight through, or
// holds it and stalls the master when the output stage cannot accept it yet.
module custom_busmatrix_input_stage (
  input logic HCLK,
  input logic HRESETn,
  custom_busmatrix_input_stage_if.slave bus
);

  typedef enum logic {IDLE, HELD} state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] addr_reg;
  logic        write_reg;
  logic [2:0]  size_reg;
  logic [2:0]  burst_reg;
  logic [3:0]  prot_reg;
  logic [1:0]  trans_reg;
  logic        trans_valid;
  logic        held;
  logic        load;

  assign trans_valid = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS;
  assign held        = (state_reg == HELD);
  // the master is stalled while HELD, so any valid-looking phase there is ignored
  assign load        = trans_valid & ~held;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (trans_valid && !bus.active_in) state_next = HELD;
      HELD:    if (bus.active_in)                 state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      trans_reg <= '0;
      write_reg <= 1'b0;
      size_reg  <= '0;
      burst_reg <= '0;
      prot_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        addr_reg  <= bus.HADDRS;
        trans_reg <= bus.HTRANSS;
        write_reg <= bus.HWRITES;
        size_reg  <= bus.HSIZES;
        burst_reg <= bus.HBURSTS;
        prot_reg  <= bus.HPROTS;
      end
    end
  end

  // a held phase is always re-presented as NONSEQ, even if it was captured as SEQ
  assign bus.sel_in       = held ? 1'b1        : bus.HSELS;
  assign bus.addr_in      = held ? addr_reg    : bus.HADDRS;
  assign bus.trans_in     = held ? {trans_reg[1], 1'b0} : bus.HTRANSS;
  assign bus.write_in     = held ? write_reg   : bus.HWRITES;
  assign bus.size_in      = held ? size_reg    : bus.HSIZES;
  assign bus.burst_in     = held ? burst_reg   : bus.HBURSTS;
  assign bus.prot_in      = held ? prot_reg    : bus.HPROTS;
  assign bus.held_tran_in = held;
  assign bus.HREADYOUTS   = held ? 1'b0  : bus.readyout_in;
  assign bus.HRESPS       = held ? 2'b00 : bus.resp_in;

endmodule

// File: tb/tb_custom_busmatrix_input_stage.sv
// Self-checking bench: a cycle-by-cycle vector table fed through a scoreboard,
// plus hand-written asynchronous-reset sequences.
module tb_custom_busmatrix_input_stage;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;

  custom_busmatrix_input_stage_if bus ();

  custom_busmatrix_input_stage dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        rdy;
    logic        active;
    logic        readyout;
    logic [1:0]  resp;
    logic [10:0] attr;
    logic        e_held;
    logic        e_sel;
    logic [31:0] e_addr;
    logic [1:0]  e_trans;
    logic [10:0] e_attr;
    logic        e_hready;
    logic [1:0]  e_resp;
  } vec_t;

  typedef struct {
    logic        held;
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [10:0] attr;
    logic        hready;
    logic [1:0]  resp;
  } exp_t;

  vec_t vecs[16];
  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    bus.HSELS       = v.sel;
    bus.HTRANSS     = v.trans;
    bus.HADDRS      = v.addr;
    bus.HREADYS     = v.rdy;
    bus.active_in   = v.active;
    bus.readyout_in = v.readyout;
    bus.resp_in     = v.resp;
    {bus.HWRITES, bus.HSIZES, bus.HBURSTS, bus.HPROTS} = v.attr;
    e.held   = v.e_held;
    e.sel    = v.e_sel;
    e.addr   = v.e_addr;
    e.trans  = v.e_trans;
    e.attr   = v.e_attr;
    e.hready = v.e_hready;
    e.resp   = v.e_resp;
    sb.push_back(e);
  endtask

  task automatic compare_out(input int idx);
    exp_t e;
    if (sb.size() == 0) begin
      check($sformatf("v%0d scoreboard_empty", idx), 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check($sformatf("v%0d held_tran_in", idx), {31'd0, bus.held_tran_in}, {31'd0, e.held});
    check($sformatf("v%0d sel_in", idx), {31'd0, bus.sel_in}, {31'd0, e.sel});
    check($sformatf("v%0d addr_in", idx), bus.addr_in, e.addr);
    check($sformatf("v%0d trans_in", idx), {30'd0, bus.trans_in}, {30'd0, e.trans});
    check($sformatf("v%0d attr", idx),
          {21'd0, bus.write_in, bus.size_in, bus.burst_in, bus.prot_in}, {21'd0, e.attr});
    check($sformatf("v%0d HREADYOUTS", idx), {31'd0, bus.HREADYOUTS}, {31'd0, e.hready});
    check($sformatf("v%0d HRESPS", idx), {30'd0, bus.HRESPS}, {30'd0, e.resp});
    $display("vec %0d: held=%0d addr=%h trans=%b hready=%0d resp=%b",
             idx, bus.held_tran_in, bus.addr_in, bus.trans_in, bus.HREADYOUTS, bus.HRESPS);
  endtask

  initial begin
    // sel trans addr rdy act rdyout resp attr | held sel addr trans attr hready resp
    vecs[0]  = '{1'b1, 2'b10, 32'h20000010, 1'b1, 1'b1, 1'b1, 2'b00, 11'h53A,
                 1'b0, 1'b1, 32'h20000010, 2'b10, 11'h53A, 1'b1, 2'b00};
    vecs[1]  = '{1'b1, 2'b10, 32'h20000010, 1'b1, 1'b0, 1'b1, 2'b00, 11'h53A,
                 1'b0, 1'b1, 32'h20000010, 2'b10, 11'h53A, 1'b1, 2'b00};
    vecs[2]  = '{1'b0, 2'b00, 32'hDEAD0000, 1'b0, 1'b0, 1'b1, 2'b00, 11'h000,
                 1'b1, 1'b1, 32'h20000010, 2'b10, 11'h53A, 1'b0, 2'b00};
    vecs[3]  = '{1'b0, 2'b00, 32'hDEAD0000, 1'b0, 1'b0, 1'b1, 2'b01, 11'h000,
                 1'b1, 1'b1, 32'h20000010, 2'b10, 11'h53A, 1'b0, 2'b00};
    vecs[4]  = '{1'b0, 2'b00, 32'hDEAD0000, 1'b0, 1'b0, 1'b1, 2'b00, 11'h000,
                 1'b1, 1'b1, 32'h20000010, 2'b10, 11'h53A, 1'b0, 2'b00};
    vecs[5]  = '{1'b0, 2'b00, 32'hDEAD0000, 1'b0, 1'b1, 1'b1, 2'b00, 11'h000,
                 1'b1, 1'b1, 32'h20000010, 2'b10, 11'h53A, 1'b0, 2'b00};
    vecs[6]  = '{1'b1, 2'b00, 32'h00000000, 1'b1, 1'b0, 1'b1, 2'b00, 11'h123,
                 1'b0, 1'b1, 32'h00000000, 2'b00, 11'h123, 1'b1, 2'b00};
    vecs[7]  = '{1'b1, 2'b00, 32'h00000004, 1'b1, 1'b0, 1'b0, 2'b00, 11'h123,
                 1'b0, 1'b1, 32'h00000004, 2'b00, 11'h123, 1'b0, 2'b00};
    vecs[8]  = '{1'b1, 2'b11, 32'h50000004, 1'b1, 1'b0, 1'b1, 2'b00, 11'h2C5,
                 1'b0, 1'b1, 32'h50000004, 2'b11, 11'h2C5, 1'b1, 2'b00};
    vecs[9]  = '{1'b0, 2'b00, 32'h00000000, 1'b0, 1'b0, 1'b1, 2'b00, 11'h000,
                 1'b1, 1'b1, 32'h50000004, 2'b10, 11'h2C5, 1'b0, 2'b00};
    vecs[10] = '{1'b1, 2'b10, 32'h12345678, 1'b1, 1'b0, 1'b1, 2'b00, 11'h7FF,
                 1'b1, 1'b1, 32'h50000004, 2'b10, 11'h2C5, 1'b0, 2'b00};
    vecs[11] = '{1'b0, 2'b00, 32'h00000000, 1'b0, 1'b1, 1'b1, 2'b00, 11'h000,
                 1'b1, 1'b1, 32'h50000004, 2'b10, 11'h2C5, 1'b0, 2'b00};
    vecs[12] = '{1'b0, 2'b00, 32'h00000000, 1'b1, 1'b0, 1'b0, 2'b01, 11'h000,
                 1'b0, 1'b0, 32'h00000000, 2'b00, 11'h000, 1'b0, 2'b01};
    vecs[13] = '{1'b0, 2'b00, 32'h00000000, 1'b1, 1'b0, 1'b1, 2'b01, 11'h000,
                 1'b0, 1'b0, 32'h00000000, 2'b00, 11'h000, 1'b1, 2'b01};
    vecs[14] = '{1'b1, 2'b01, 32'h00000008, 1'b1, 1'b0, 1'b1, 2'b00, 11'h0F0,
                 1'b0, 1'b1, 32'h00000008, 2'b01, 11'h0F0, 1'b1, 2'b00};
    vecs[15] = '{1'b1, 2'b01, 32'h00000008, 1'b1, 1'b0, 1'b1, 2'b00, 11'h0F0,
                 1'b0, 1'b1, 32'h00000008, 2'b01, 11'h0F0, 1'b1, 2'b00};

    // reset state: pass-through with no held phase
    bus.HSELS = 1'b1; bus.HTRANSS = 2'b10; bus.HADDRS = 32'h0000_1000; bus.HREADYS = 1'b1;
    bus.HWRITES = 1'b0; bus.HSIZES = 3'd0; bus.HBURSTS = 3'd0; bus.HPROTS = 4'd0;
    bus.active_in = 1'b0; bus.readyout_in = 1'b0; bus.resp_in = 2'b00;
    repeat (2) @(posedge HCLK);
    #1;
    check("rst held_tran_in", {31'd0, bus.held_tran_in}, 32'd0);
    check("rst HREADYOUTS lo", {31'd0, bus.HREADYOUTS}, 32'd0);
    bus.readyout_in = 1'b1;
    #1;
    check("rst HREADYOUTS hi", {31'd0, bus.HREADYOUTS}, 32'd1);
    check("rst addr_in", bus.addr_in, 32'h0000_1000);
    bus.HSELS = 1'b0;
    #1 HRESETn = 1'b1;

    // table-driven vectors, one per clock cycle
    for (int i = 0; i < 16; i++) begin
      @(posedge HCLK);
      #1 drive(vecs[i]);
      #3 compare_out(i);
    end

    // asynchronous reset while holding a transfer
    @(posedge HCLK);
    #1;
    bus.HSELS = 1'b1; bus.HTRANSS = 2'b10; bus.HADDRS = 32'hABCD0000; bus.HREADYS = 1'b1;
    bus.active_in = 1'b0; bus.readyout_in = 1'b1; bus.resp_in = 2'b00;
    @(posedge HCLK);
    #1;
    bus.HSELS = 1'b0; bus.HTRANSS = 2'b00; bus.HREADYS = 1'b0;
    check("arst pre held", {31'd0, bus.held_tran_in}, 32'd1);
    check("arst pre addr", bus.addr_in, 32'hABCD0000);
    #2 HRESETn = 1'b0;
    #1;
    check("arst held_tran_in", {31'd0, bus.held_tran_in}, 32'd0);
    check("arst HREADYOUTS", {31'd0, bus.HREADYOUTS}, 32'd1);
    $display("arst: held=%0d hready=%0d", bus.held_tran_in, bus.HREADYOUTS);

    // first edge after release: zero-wait stays IDLE, then a stall enters HELD
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    bus.HSELS = 1'b1; bus.HTRANSS = 2'b10; bus.HADDRS = 32'h3000_0000; bus.HREADYS = 1'b1;
    bus.active_in = 1'b1;
    @(posedge HCLK);
    #1;
    check("post-rst zero-wait held", {31'd0, bus.held_tran_in}, 32'd0);
    bus.active_in = 1'b0;
    @(posedge HCLK);
    #1;
    bus.HREADYS = 1'b0;
    check("post-rst stall held", {31'd0, bus.held_tran_in}, 32'd1);
    check("post-rst stall addr", bus.addr_in, 32'h3000_0000);
    $display("post-rst: held=%0d addr=%h", bus.held_tran_in, bus.addr_in);

    check("scoreboard drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
